// File: rtl/sram_ctrl_pkg.sv
// Shared default widths and payload types for the 1RW+1R SRAM requester front end.
`timescale 1ns/1ps
package sram_ctrl_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 8;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int RSP_DEPTH  = 4;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NUM_WMASKS-1:0] wmask;
  } req_a_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;
endpackage

// File: rtl/sram_1rw1r_ctrl_if.sv
// Request/response channels between a requester (master) and the SRAM front end (slave).
`timescale 1ns/1ps
interface sram_1rw1r_ctrl_if #(
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
  parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS
);
  logic                  a_valid;
  logic                  a_ready;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [NUM_WMASKS-1:0] a_wmask;
  logic                  a_rvalid;
  logic                  a_rready;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_rvalid;
  logic                  b_rready;
  logic [DATA_WIDTH-1:0] b_rdata;

  modport master (
    output a_valid, a_we, a_addr, a_wdata, a_wmask, a_rready, b_valid, b_addr, b_rready,
    input  a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata, a_wmask, a_rready, b_valid, b_addr, b_rready,
    output a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata
  );
endinterface

// File: rtl/sram_ctrl_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; pointers wrap on the power-of-two depth.
`timescale 1ns/1ps
module sram_ctrl_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = RSP_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rstb_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW:0]      count_q, count_d;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_i) wrPtr_d = wrPtr_q + PW'(1);
    if (pop_i)  rdPtr_d = rdPtr_q + PW'(1);
    if (push_i && !pop_i)      count_d = count_q + (PW+1)'(1);
    else if (pop_i && !push_i) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;
endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// Front end for the OpenRAM 1RW+1R macro: channel A drives port 0, channel B drives port 1.
// Define SRAM_CTRL_HAZARD_STALL_EN to stall a B read that collides with a same-address A write.
`timescale 1ns/1ps
module sram_1rw1r_ctrl #(
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
  parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS,
  parameter int RSP_DEPTH  = sram_ctrl_pkg::RSP_DEPTH
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  sram_1rw1r_ctrl_if.slave      bus,
  output logic                  csb0_o,
  output logic                  web0_o,
  output logic [NUM_WMASKS-1:0] wmask0_o,
  output logic [ADDR_WIDTH-1:0] addr0_o,
  output logic [DATA_WIDTH-1:0] din0_o,
  input  logic [DATA_WIDTH-1:0] dout0_i,
  output logic                  csb1_o,
  output logic [ADDR_WIDTH-1:0] addr1_o,
  input  logic [DATA_WIDTH-1:0] dout1_i
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic                  aInflight_q, aInflight_d;
  logic                  bInflight_q, bInflight_d;
  logic                  aFire, bFire, hazard;
  logic                  aPop, bPop;
  logic [CW-1:0]         aCount, bCount, aUsed, bUsed;
  logic [DATA_WIDTH-1:0] aHead, bHead;

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign aUsed = aCount + CW'(aInflight_q);
  assign bUsed = bCount + CW'(bInflight_q);

`ifdef SRAM_CTRL_HAZARD_STALL_EN
  assign hazard = bus.a_valid && bus.a_we && bus.b_valid && (bus.a_addr == bus.b_addr);
`else
  assign hazard = 1'b0;
`endif

  assign bus.a_ready = rstb0 && (aUsed < CW'(RSP_DEPTH));
  assign bus.b_ready = rstb0 && (bUsed < CW'(RSP_DEPTH)) && !hazard;
  assign aFire       = bus.a_valid && bus.a_ready;
  assign bFire       = bus.b_valid && bus.b_ready;

  assign csb0_o   = !aFire;
  assign web0_o   = !(rstb0 && bus.a_we);
  assign addr0_o  = bus.a_addr;
  assign din0_o   = bus.a_wdata;
  assign wmask0_o = bus.a_wmask;
  assign csb1_o   = !bFire;
  assign addr1_o  = bus.b_addr;

  always_comb begin
    aInflight_d = aFire && !bus.a_we;
    bInflight_d = bFire;
  end

  // The macro launches dout on the negedge, so a flagged read is captured one posedge later.
  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      aInflight_q <= 1'b0;
      bInflight_q <= 1'b0;
    end else begin
      aInflight_q <= aInflight_d;
      bInflight_q <= bInflight_d;
    end
  end

  sram_ctrl_rsp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_a_fifo (
    .clk_i   (clk0),
    .rstb_i  (rstb0),
    .push_i  (aInflight_q),
    .wdata_i (dout0_i),
    .pop_i   (aPop),
    .rdata_o (aHead),
    .count_o (aCount)
  );

  sram_ctrl_rsp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_b_fifo (
    .clk_i   (clk0),
    .rstb_i  (rstb0),
    .push_i  (bInflight_q),
    .wdata_i (dout1_i),
    .pop_i   (bPop),
    .rdata_o (bHead),
    .count_o (bCount)
  );

  assign bus.a_rvalid = rstb0 && (aCount != '0);
  assign bus.b_rvalid = rstb0 && (bCount != '0);
  assign bus.a_rdata  = bus.a_rvalid ? aHead : '0;
  assign bus.b_rdata  = bus.b_rvalid ? bHead : '0;
  assign aPop         = bus.a_rvalid && bus.a_rready;
  assign bPop         = bus.b_rvalid && bus.b_rready;
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// Randomized scoreboard bench for sram_1rw1r_ctrl with a behavioural model of the OpenRAM macro.
// Honors SRAM_CTRL_HAZARD_STALL_EN the same way the design does.
`timescale 1ns/1ps
module tb_sram_1rw1r_ctrl;
  import sram_ctrl_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int NW    = 4;
  localparam int DEPTH = 4;

  logic clk0 = 1'b0;
  logic rstb0;
  always #5 clk0 = ~clk0;

  sram_1rw1r_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) bus ();

  logic          csb0, web0, csb1;
  logic [NW-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, dout0, dout1;

  sram_1rw1r_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW), .RSP_DEPTH(DEPTH)) dut (
    .clk0     (clk0),
    .rstb0    (rstb0),
    .bus      (bus),
    .csb0_o   (csb0),
    .web0_o   (web0),
    .wmask0_o (wmask0),
    .addr0_o  (addr0),
    .din0_o   (din0),
    .dout0_i  (dout0),
    .csb1_o   (csb1),
    .addr1_o  (addr1),
    .dout1_i  (dout1)
  );

  int checks = 0;
  int errors = 0;

  // Macro model: pins sampled at posedge, write then reads performed at the following negedge.
  logic [DW-1:0] macroMem [2**AW];
  logic [DW-1:0] refMem   [2**AW];
  logic          lCsb0, lWeb0, lCsb1;
  logic [AW-1:0] lAddr0, lAddr1;
  logic [DW-1:0] lDin0;
  logic [NW-1:0] lMask0;

  always @(posedge clk0) begin
    lCsb0  <= csb0;
    lWeb0  <= web0;
    lAddr0 <= addr0;
    lDin0  <= din0;
    lMask0 <= wmask0;
    lCsb1  <= csb1;
    lAddr1 <= addr1;
  end

  always @(negedge clk0) begin
    if (lCsb0 === 1'b0 && lWeb0 === 1'b0)
      for (int i = 0; i < NW; i++)
        if (lMask0[i]) macroMem[lAddr0][8*i +: 8] = lDin0[8*i +: 8];
    dout0 = (lCsb0 === 1'b0 && lWeb0 === 1'b1) ? macroMem[lAddr0] : $urandom;
    dout1 = (lCsb1 === 1'b0) ? macroMem[lAddr1] : $urandom;
  end

  typedef struct {
    rsp_t rsp;
    bit   care;
  } exp_t;

  exp_t aExpQ[$];
  exp_t bExpQ[$];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, got, expv);
    end
  endtask

  // Request side: credit and pin rules checked, accepted requests applied to the reference memory.
  always @(negedge clk0) begin : reqMon
    bit   expA, expB, hz;
    exp_t e;
    hz = 1'b0;
`ifdef SRAM_CTRL_HAZARD_STALL_EN
    hz = bus.a_valid && bus.a_we && bus.b_valid && (bus.a_addr == bus.b_addr);
`endif
    expA = (rstb0 === 1'b1) && (aExpQ.size() < DEPTH);
    expB = (rstb0 === 1'b1) && (bExpQ.size() < DEPTH) && !hz;
    checkOutput("a_ready", {31'b0, bus.a_ready}, {31'b0, expA});
    checkOutput("b_ready", {31'b0, bus.b_ready}, {31'b0, expB});
    checkOutput("csb0", {31'b0, csb0}, {31'b0, !(bus.a_valid && expA)});
    checkOutput("csb1", {31'b0, csb1}, {31'b0, !(bus.b_valid && expB)});
    if (rstb0 !== 1'b1) begin
      aExpQ.delete();
      bExpQ.delete();
    end else begin
      if (bus.b_valid && expB) begin
        e.rsp.rdata = refMem[bus.b_addr];
        e.care      = !(bus.a_valid && expA && bus.a_we && bus.a_addr == bus.b_addr);
        bExpQ.push_back(e);
      end
      if (bus.a_valid && expA) begin
        if (bus.a_we) begin
          for (int i = 0; i < NW; i++)
            if (bus.a_wmask[i]) refMem[bus.a_addr][8*i +: 8] = bus.a_wdata[8*i +: 8];
        end else begin
          e.rsp.rdata = refMem[bus.a_addr];
          e.care      = 1'b1;
          aExpQ.push_back(e);
        end
      end
    end
  end

  // Response side: each pop is matched against the oldest outstanding expectation.
  always @(negedge clk0) begin : rspMon
    exp_t e;
    #1;
    if (rstb0 === 1'b1 && bus.a_rvalid && bus.a_rready) begin
      if (aExpQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL a_rvalid_unexpected got 1 expected 0");
      end else begin
        e = aExpQ.pop_front();
        if (e.care) checkOutput("a_rdata", bus.a_rdata, e.rsp.rdata);
      end
    end
    if (rstb0 === 1'b1 && bus.b_rvalid && bus.b_rready) begin
      if (bExpQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL b_rvalid_unexpected got 1 expected 0");
      end else begin
        e = bExpQ.pop_front();
        if (e.care) checkOutput("b_rdata", bus.b_rdata, e.rsp.rdata);
      end
    end
  end

  task automatic applyStimulus(input bit aV, input bit aWe, input logic [AW-1:0] aA,
                               input logic [DW-1:0] aD, input logic [NW-1:0] aM,
                               input bit bV, input logic [AW-1:0] bA);
    bus.a_valid = aV;
    bus.a_we    = aWe;
    bus.a_addr  = aA;
    bus.a_wdata = aD;
    bus.a_wmask = aM;
    bus.b_valid = bV;
    bus.b_addr  = bA;
    #1;
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit     hzReady;
    req_a_t r;
    int     k;

    for (int i = 0; i < 2**AW; i++) begin
      macroMem[i] = $urandom;
      refMem[i]   = macroMem[i];
    end
    rstb0        = 1'b0;
    bus.a_rready = 1'b1;
    bus.b_rready = 1'b1;

    // Reset with both channels requesting: nothing may reach the macro.
    applyStimulus(1, 1, 8'h01, 32'h0, 4'hF, 1, 8'h02);
    tick();
    tick();
    checkOutput("rst_csb0", {31'b0, csb0}, 32'd1);
    checkOutput("rst_csb1", {31'b0, csb1}, 32'd1);
    checkOutput("rst_web0", {31'b0, web0}, 32'd1);
    checkOutput("rst_a_ready", {31'b0, bus.a_ready}, 32'd0);
    checkOutput("rst_b_ready", {31'b0, bus.b_ready}, 32'd0);
    checkOutput("rst_a_rvalid", {31'b0, bus.a_rvalid}, 32'd0);
    checkOutput("rst_b_rvalid", {31'b0, bus.b_rvalid}, 32'd0);
    checkOutput("rst_a_rdata", bus.a_rdata, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rstb0 = 1'b1;
    tick();
    checkOutput("rel_a_ready", {31'b0, bus.a_ready}, 32'd1);
    checkOutput("rel_b_ready", {31'b0, bus.b_ready}, 32'd1);

    // Full write then read-back on A with one-cycle latency.
    applyStimulus(1, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    tick();
    applyStimulus(1, 0, 8'h10, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("wr_rd_rvalid_early", {31'b0, bus.a_rvalid}, 32'd0);
    tick();
    checkOutput("wr_rd_rvalid", {31'b0, bus.a_rvalid}, 32'd1);
    checkOutput("wr_rd_rdata", bus.a_rdata, 32'hDEADBEEF);

    // Byte-masked write, read back through B.
    applyStimulus(1, 1, 8'h10, 32'h11223344, 4'b0101, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 8'h10);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("mask_b_rvalid", {31'b0, bus.b_rvalid}, 32'd1);
    checkOutput("mask_b_rdata", bus.b_rdata, 32'hDE22BE44);

    // Same-address collision: A always wins.
`ifdef SRAM_CTRL_HAZARD_STALL_EN
    hzReady = 1'b0;
`else
    hzReady = 1'b1;
`endif
    applyStimulus(1, 1, 8'h20, 32'hA5A5A5A5, 4'hF, 1, 8'h20);
    checkOutput("hz_b_ready", {31'b0, bus.b_ready}, {31'b0, hzReady});
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 8'h20);
    checkOutput("hz_b_ready_next", {31'b0, bus.b_ready}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("hz_b_rvalid", {31'b0, bus.b_rvalid}, 32'd1);
    checkOutput("hz_b_rdata", bus.b_rdata, 32'hA5A5A5A5);

    // Backpressure: four reads fill the credits, the fifth waits for a pop.
    bus.a_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, AW'(i), 0, 0, 0, 0);
      checkOutput("bp_accept", {31'b0, bus.a_ready}, 32'd1);
      tick();
    end
    applyStimulus(1, 0, 8'd4, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_full", {31'b0, bus.a_ready}, 32'd0);
      tick();
    end
    bus.a_rready = 1'b1;
    #1;
    checkOutput("bp_no_same_cycle_credit", {31'b0, bus.a_ready}, 32'd0);
    checkOutput("bp_head0", bus.a_rdata, refMem[0]);
    tick();
    checkOutput("bp_recover", {31'b0, bus.a_ready}, 32'd1);
    tick();
    applyStimulus(1, 0, 8'd5, 0, 0, 0, 0);
    k = 0;
    while (!bus.a_ready && k < 10) begin
      tick();
      k++;
    end
    checkOutput("bp_read5_ready", {31'b0, bus.a_ready}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (8) tick();

    // Reset while a read is in flight: its capture must vanish.
    applyStimulus(1, 0, 8'h30, 0, 0, 0, 0);
    tick();
    rstb0 = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rstb0 = 1'b1;
    #1;
    checkOutput("mid_rst_a_ready", {31'b0, bus.a_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("mid_rst_a_rvalid", {31'b0, bus.a_rvalid}, 32'd0);
      tick();
    end

    // Random traffic on a narrow address window to provoke collisions and read-after-write.
    for (int c = 0; c < 600; c++) begin
      r.we    = 1'($urandom_range(0, 1));
      r.addr  = AW'($urandom_range(0, 15));
      r.wdata = $urandom;
      r.wmask = NW'($urandom_range(0, 15));
      bus.a_rready = ($urandom_range(0, 3) != 0);
      bus.b_rready = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 3) != 0, r.we, r.addr, r.wdata, r.wmask,
                    $urandom_range(0, 2) != 0, AW'($urandom_range(0, 15)));
      tick();
    end

    bus.a_rready = 1'b1;
    bus.b_rready = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (10) tick();
    checkOutput("drain_a", 32'(aExpQ.size()), 32'd0);
    checkOutput("drain_b", 32'(bExpQ.size()), 32'd0);
    checkOutput("drain_a_rvalid", {31'b0, bus.a_rvalid}, 32'd0);
    checkOutput("drain_b_rvalid", {31'b0, bus.b_rvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_1rw1r_ctrl.md
# sram_1rw1r_ctrl

Synchronous requester front end for the 1RW+1R OpenRAM macro (32x256, byte write mask). Converts two valid/ready request channels into the macro's pins: channel A (read/write) drives port 0, channel B (read-only) drives port 1. It captures the macro's negedge-launched read data into per-channel response FIFOs with credit-based backpressure, and resolves same-address write/read collisions. It sits between a core or DMA and the hard macro; the macro's clk0 and clk1 are both tied to this block's clock.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 8, address width
- NUM_WMASKS, 4, byte lanes (DATA_WIDTH/8)
- RSP_DEPTH, 4, entries per response FIFO (power of 2, >=2)

- clk0  in  1  single clock, rising edge; also drives macro clk0/clk1
- rstb0  in  1  synchronous active-low reset
- a_valid / a_ready  in/out  1  channel A request handshake
- a_we  in  1  1=write, 0=read
- a_addr  in  ADDR_WIDTH  channel A address
- a_wdata  in  DATA_WIDTH  write data
- a_wmask  in  NUM_WMASKS  byte enables
- a_rvalid / a_rready  out/in  1  channel A read response handshake
- a_rdata  out  DATA_WIDTH  channel A read data
- b_valid / b_ready  in/out  1  channel B read request handshake
- b_addr  in  ADDR_WIDTH  channel B address
- b_rvalid / b_rready  out/in  1  channel B response handshake
- b_rdata  out  DATA_WIDTH  channel B read data
- csb0, web0  out  1  macro port 0 chip select / write enable (active low)
- wmask0  out  NUM_WMASKS; addr0  out  ADDR_WIDTH; din0  out  DATA_WIDTH
- dout0  in  DATA_WIDTH  macro port 0 read data
- csb1  out  1; addr1  out  ADDR_WIDTH; dout1  in  DATA_WIDTH  macro port 1

## Operation
- Macro pins are combinational from the handshake: csb0 = !(a_valid&&a_ready); web0 = !a_we; addr0/din0/wmask0 = channel A payload. Likewise csb1 = !(b_valid&&b_ready); addr1 = b_addr.
- Read accepted at posedge N: macro samples at N, launches dout at negedge N, block captures dout0/dout1 into the FIFO at posedge N+1. One in-flight flag per channel marks the pending capture.
- Writes produce no response.
- Credits: a_ready = rstb0 && (a_fifo_count + a_inflight < RSP_DEPTH), for reads and writes alike. Ready never depends on a_we. b_ready likewise, plus the hazard term.
- Hazard (with macro enabled): a_valid && a_we && b_valid && a_addr==b_addr forces b_ready=0. A always wins. B is issued the next cycle and returns the new data.
- Responses are returned in order per channel. There is no ordering between channels.
- FIFO pop occurs when rvalid && rready. A pop does not free a credit in the same cycle.

## Timing
- Reset (rstb0=0 at posedge): FIFOs emptied, inflight flags cleared.
  - a_rvalid = b_rvalid = 0; rdata = 0.
  - a_ready = b_ready = 0 while rstb0 is low, so csb0 = csb1 = 1 and web0 = 1.
- Read latency: rvalid is high in the cycle after the request handshake when the FIFO was empty.
- Throughput: 1 op/cycle per channel while rready is held high.
- Write at N followed by a read of the same address at N+1 on either port returns the new data, because the write lands at negedge N.
- Reset mid-flight: the pending capture is discarded and no rvalid is asserted after release.
- FIFO full: count + inflight == RSP_DEPTH drops ready. Ready recovers the cycle after a pop.
- Address wraps naturally at 2^ADDR_WIDTH. There is no bounds check.

## Configuration
- SRAM_CTRL_HAZARD_STALL_EN defined: same-address collision stalls B as described above.
- SRAM_CTRL_HAZARD_STALL_EN undefined: no comparator. b_ready is credit-only, and a colliding B read returns whatever the macro outputs (undefined). This saves area for users that guarantee disjoint addresses.

## Structure
- Package sram_ctrl_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_WMASKS defaults
  - typedef req_a_t {we, addr, wdata, wmask}
  - typedef rsp_t {rdata}
- Sub-module sram_ctrl_rsp_fifo: synchronous FIFO (depth RSP_DEPTH, count output, synchronous active-low reset). It is instantiated once per channel.

## Test plan
- Reset: hold rstb0=0 for 2 cycles -> csb0=csb1=1, a_ready=b_ready=0, rvalids 0. The cycle after release, a_ready=b_ready=1.
- Write A addr 0x10 data 0xDEADBEEF mask 4'hF, then read A 0x10 -> a_rvalid one cycle after the read handshake, a_rdata=0xDEADBEEF.
- Byte mask: write 0x11223344 mask 4'b0101 onto 0xDEADBEEF at 0x10, then read B 0x10 -> b_rdata=0xDE22BE44.
- Hazard: same cycle, A writes 0xA5A5A5A5 to 0x20 and B reads 0x20 -> b_ready=0 that cycle; B is accepted next cycle and returns 0xA5A5A5A5. With the macro undefined, B is accepted immediately.
- Backpressure: a_rready=0 with 6 back-to-back A reads of 0..5 -> 4 accepted, then a_ready=0. Raising a_rready drains mem[0..3] in order, then the remaining reads are accepted.
- Reset mid-flight: A read handshake at N, rstb0=0 at N+1 -> a_rvalid stays 0 after release, FIFO count 0.
